// File: rtl/mult_acc_radix_if.sv
// ---------------------------------------------------------------------------
// mult_acc_radix_if
//
// Operand/result bundle for the radix multiply-accumulate unit.
//
// Signals:
//   a_in      [WIDTH-1:0]    multiplicand, captured on accept
//   b_in      [WIDTH-1:0]    multiplier, captured on accept
//   d_in      [WIDTH-1:0]    addend, captured on accept (0 for a plain multiply)
//   valid_in                 start request, sampled only while idle
//   c_out     [2*WIDTH-1:0]  result a*b + d, held until the next result
//   valid_out                single-cycle pulse when c_out is updated
//   busy_out                 high while an operation is in flight
//
// Modports:
//   master : requester side (drives operands and valid_in)
//   slave  : the multiply-accumulate unit
// ---------------------------------------------------------------------------
interface mult_acc_radix_if #(
  parameter int WIDTH = 256
);

  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [WIDTH-1:0]   d_in;
  logic               valid_in;
  logic [2*WIDTH-1:0] c_out;
  logic               valid_out;
  logic               busy_out;

  modport master (
    output a_in,
    output b_in,
    output d_in,
    output valid_in,
    input  c_out,
    input  valid_out,
    input  busy_out
  );

  modport slave (
    input  a_in,
    input  b_in,
    input  d_in,
    input  valid_in,
    output c_out,
    output valid_out,
    output busy_out
  );

endinterface : mult_acc_radix_if

// File: rtl/mult_acc_radix.sv
// ---------------------------------------------------------------------------
// mult_acc_radix
//
// Multi-cycle unsigned multiply-accumulate: c = a*b + d.
// DIGIT_BITS bits of the multiplier are retired per clock, so an operation
// takes NUM_DIGITS = WIDTH/DIGIT_BITS cycles. The valid/busy handshake
// matches the bit-serial multiplier it replaces.
//
// Parameters:
//   WIDTH       operand width; must be a multiple of DIGIT_BITS
//   DIGIT_BITS  multiplier bits per cycle: 1, 2, 4 or 8
//
// Ports:
//   clk_in  clock, all state updates on the rising edge
//   rst_in  asynchronous active-high reset; aborts any operation in flight
//   bus     mult_acc_radix_if.slave (operands, valid_in, c_out, valid_out,
//           busy_out)
//
// Timing: accept on edge E0 (valid_in while idle); busy_out is high for the
// next NUM_DIGITS cycles; c_out and the valid_out pulse appear after edge
// E0+NUM_DIGITS, in a cycle where the unit is already idle again so a new
// request can be accepted immediately.
// ---------------------------------------------------------------------------
module mult_acc_radix #(
  parameter int WIDTH      = 256,
  parameter int DIGIT_BITS = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  mult_acc_radix_if.slave bus
);

  localparam int NUM_DIGITS = WIDTH / DIGIT_BITS;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  // Elaboration-time guard against unsupported configurations.
  if ((WIDTH % DIGIT_BITS) != 0 ||
      !(DIGIT_BITS == 1 || DIGIT_BITS == 2 || DIGIT_BITS == 4 || DIGIT_BITS == 8))
  begin : g_param_check
    $error("mult_acc_radix: illegal WIDTH/DIGIT_BITS combination");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // a_reg holds the multiplicand already shifted to the weight of the
  // current digit, so each cycle adds an aligned partial product without a
  // variable shifter. Its top WIDTH bits start at zero; a*2^(WIDTH-DIGIT_BITS)
  // still fits in 2*WIDTH bits, so nothing is lost off the top.
  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] partial;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] c_reg;
  logic               valid_reg;

  logic accept;
  logic busy;
  logic last_digit;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others, matching hardware.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and control decode
  // -------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    last_digit = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.valid_in) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // valid_in is deliberately ignored here: no queueing, no re-sampling.
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          last_digit = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Partial product: a_reg * (low digit of b_reg), built as a small sum of
  // shifted copies so the multiplier stays DIGIT_BITS wide.
  // -------------------------------------------------------------------------
  always_comb begin
    partial = '0;
    for (int j = 0; j < DIGIT_BITS; j++) begin
      if (b_reg[j]) begin
        partial = partial + (a_reg << j);
      end
    end
  end

  // The final sum is bounded by 2^(2W) - 2^W, so the 2W-bit add never carries
  // out and no wider accumulator is needed.
  assign acc_next = acc + partial;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: the whole datapath is reset, not just the control state, so an
  // aborted operation leaves no stale operands, partial sums or result behind.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      c_reg     <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (accept) begin
        a_reg <= {{WIDTH{1'b0}}, bus.a_in};
        b_reg <= bus.b_in;
        acc   <= {{WIDTH{1'b0}}, bus.d_in};
        cnt   <= '0;
      end else if (busy) begin
        a_reg <= a_reg << DIGIT_BITS;
        b_reg <= b_reg >> DIGIT_BITS;
        acc   <= acc_next;
        cnt   <= cnt + 1'b1;
        if (last_digit) begin
          // c_out only changes here, so it holds across later accepts/RUNs.
          c_reg     <= acc_next;
          valid_reg <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // busy_out decodes the state register directly, so an asynchronous reset
  // drops it without waiting for a clock edge.
  assign bus.busy_out  = busy;
  assign bus.valid_out = valid_reg;
  assign bus.c_out     = c_reg;

endmodule : mult_acc_radix

// File: tb/tb_mult_acc_radix.sv
// ---------------------------------------------------------------------------
// tb_mult_acc_radix
//
// Self-checking bench for mult_acc_radix. A W=256/DB=4 instance covers the
// functional, protocol and reset scenarios; four W=16 instances (DB = 1, 2,
// 4, 8) run the radix sweep in parallel. Expected results for the main unit
// are pushed to a scoreboard queue at issue time and popped when valid_out
// fires. All driving and sampling happens on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mult_acc_radix;

  localparam int W  = 256;
  localparam int DB = 4;
  localparam int N  = W / DB;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [2*W-1:0] sb [$];
  logic [2*W-1:0] last_c = '0;

  // -------------------------------------------------------------------------
  // Main DUT
  // -------------------------------------------------------------------------
  mult_acc_radix_if #(.WIDTH(W)) bus ();

  mult_acc_radix #(
    .WIDTH      (W),
    .DIGIT_BITS (DB)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // -------------------------------------------------------------------------
  // Radix-sweep DUTs: W=16, DIGIT_BITS = 1 << g
  // -------------------------------------------------------------------------
  logic [15:0] sw_a = '0;
  logic [15:0] sw_b = '0;
  logic [15:0] sw_d = '0;
  logic        sw_valid_in = 1'b0;
  logic [3:0]  sw_valid_out;
  logic [3:0]  sw_busy;
  logic [31:0] sw_c [4];

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    mult_acc_radix_if #(.WIDTH(16)) sif ();

    assign sif.a_in     = sw_a;
    assign sif.b_in     = sw_b;
    assign sif.d_in     = sw_d;
    assign sif.valid_in = sw_valid_in;
    assign sw_valid_out[g] = sif.valid_out;
    assign sw_busy[g]      = sif.busy_out;
    assign sw_c[g]         = sif.c_out;

    mult_acc_radix #(
      .WIDTH      (16),
      .DIGIT_BITS (1 << g)
    ) u_dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (sif)
    );
  end

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] d);
    logic [2*W-1:0] wa, wb, wd;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    wd = {{W{1'b0}}, d};
    return wa * wb + wd;
  endfunction

  // Called at a falling edge. Presents a request, pushes its expected result
  // and returns at the falling edge just after the accept edge E0. With
  // hold=1 valid_in stays high and the operands are scrambled during RUN.
  task automatic issue(input logic [W-1:0]   a,
                       input logic [W-1:0]   b,
                       input logic [W-1:0]   d,
                       input logic [2*W-1:0] exp,
                       input bit             hold);
    bus.a_in     = a;
    bus.b_in     = b;
    bus.d_in     = d;
    bus.valid_in = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    if (hold) begin
      bus.a_in = W'(99);
      bus.b_in = W'(5);
      bus.d_in = W'(1);
    end else begin
      bus.valid_in = 1'b0;
    end
  endtask

  // Waits (bounded) for valid_out, checking latency, busy duration, c_out
  // stability mid-RUN and the popped scoreboard value. Returns at the
  // falling edge inside the valid_out cycle.
  task automatic collect(input string name);
    int c = 0;
    int busy_n = 0;
    bit got = 1'b0;
    logic [2*W-1:0] exp;
    while (!got && c <= 2 * N + 10) begin
      if (bus.valid_out === 1'b1) begin
        got = 1'b1;
      end else begin
        if (bus.busy_out === 1'b1) busy_n++;
        if (c == N / 2) begin
          checks++;
          if (bus.c_out !== last_c) begin
            errors++;
            $display("FAIL %s_c_hold: c_out=%h expected=%h", name, bus.c_out, last_c);
          end
        end
        @(negedge clk);
        c++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no valid_out within %0d cycles", name, c);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    exp = sb.pop_front();
    if (bus.c_out !== exp) begin
      errors++;
      $display("FAIL %s_result: c_out=%h expected=%h", name, bus.c_out, exp);
    end
    checks++;
    if (c != N) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles expected %0d", name, c, N);
    end
    checks++;
    if (busy_n != N || bus.busy_out !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: high %0d cycles (now %b) expected %0d (now 0)",
               name, busy_n, bus.busy_out, N);
    end
    last_c = exp;
  endtask

  task automatic check_quiet(input int n, input string name);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.valid_out !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s_quiet: %0d spurious valid_out cycles expected 0", name, seen);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    bus.a_in = '0; bus.b_in = '0; bus.d_in = '0; bus.valid_in = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.c_out !== '0 || bus.valid_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: c_out=%h valid_out=%b busy_out=%b expected 0/0/0",
               bus.c_out, bus.valid_out, bus.busy_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small();
    issue(W'(13), W'(23), W'(0), 512'd299, 1'b0);
    collect("small");
    @(negedge clk);
    checks++;
    if (bus.valid_out !== 1'b0 || bus.c_out !== 512'd299) begin
      errors++;
      $display("FAIL small_pulse: valid_out=%b c_out=%h expected 0 and 299 held",
               bus.valid_out, bus.c_out);
    end
  endtask

  task automatic test_accumulate();
    issue(W'(13), W'(23), W'(7), 512'd306, 1'b0);
    collect("accumulate");
    @(negedge clk);
  endtask

  task automatic test_large();
    logic [W-1:0]   a, b;
    logic [2*W-1:0] exp;
    a   = 256'd308113484502254276214653084379069091219;
    b   = 256'd193690634914747133184576417654126124729;
    exp = 512'd59678696439036731833174790408137592454209857625042749229656692202628272654651;
    issue(a, b, W'(0), exp, 1'b0);
    collect("large");
    @(negedge clk);
  endtask

  task automatic test_corners();
    logic [W-1:0]   ones;
    logic [2*W-1:0] exp;
    ones = '1;
    exp  = {{W{1'b1}}, {W{1'b0}}};
    issue(ones, ones, ones, exp, 1'b0);
    collect("all_ones");
    @(negedge clk);
    issue(W'(0), rand_w(), W'(5), 512'd5, 1'b0);
    collect("zero_a");
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] a, b, d;
      a = rand_w();
      b = rand_w();
      d = rand_w();
      issue(a, b, d, model(a, b, d), 1'b0);
      collect("random");
      @(negedge clk);
    end
  endtask

  task automatic test_hold_valid();
    issue(W'(13), W'(23), W'(0), 512'd299, 1'b1);
    collect("hold_valid");
    bus.valid_in = 1'b0;
    check_quiet(2 * N, "hold_valid");
    checks++;
    if (bus.c_out !== 512'd299) begin
      errors++;
      $display("FAIL hold_valid_c: c_out=%h expected 299", bus.c_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    issue(W'(13), W'(23), W'(0), 512'd299, 1'b0);
    collect("b2b_first");
    a = rand_w();
    b = rand_w();
    issue(a, b, W'(3), model(a, b, W'(3)), 1'b0);
    collect("b2b_second");
    issue(W'(1000), W'(1000), W'(1), 512'd1000001, 1'b0);
    collect("b2b_third");
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    issue(W'(13), W'(23), W'(0), 512'd299, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.c_out !== '0 || bus.valid_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: c_out=%h valid_out=%b busy_out=%b expected 0/0/0",
               bus.c_out, bus.valid_out, bus.busy_out);
    end
    sb.delete();
    last_c = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_quiet(2 * N, "mid_reset");
    issue(W'(13), W'(23), W'(0), 512'd299, 1'b0);
    collect("after_reset");
    @(negedge clk);
  endtask

  task automatic test_radix_sweep();
    int          lat [4];
    logic [31:0] res [4];
    bit          seen [4];
    int          c = 0;
    for (int g = 0; g < 4; g++) begin
      lat[g]  = -1;
      res[g]  = '0;
      seen[g] = 1'b0;
    end
    sw_a = 16'hFFFF;
    sw_b = 16'h8001;
    sw_d = 16'h0001;
    sw_valid_in = 1'b1;
    @(negedge clk);
    sw_valid_in = 1'b0;
    while (c <= 40) begin
      for (int g = 0; g < 4; g++) begin
        if (sw_valid_out[g] === 1'b1 && !seen[g]) begin
          seen[g] = 1'b1;
          lat[g]  = c;
          res[g]  = sw_c[g];
        end
      end
      @(negedge clk);
      c++;
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (lat[g] != (16 >> g)) begin
        errors++;
        $display("FAIL sweep_db%0d_latency: got %0d expected %0d", 1 << g, lat[g], 16 >> g);
      end
      checks++;
      if (res[g] !== 32'h8000_8000) begin
        errors++;
        $display("FAIL sweep_db%0d_result: c_out=%h expected 80008000", 1 << g, res[g]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Sequence
  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_small();
    test_accumulate();
    test_large();
    test_corners();
    test_random();
    test_hold_valid();
    test_back_to_back();
    test_reset_mid_run();
    test_radix_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mult_acc_radix

// File: doc/mult_acc_radix.md
# mult_acc_radix

Parametrised multi-cycle multiply-accumulate unit for the RSA datapath. It computes c = a·b + d on unsigned operands and retires DIGIT_BITS bits of the multiplier per clock, so the radix trades area against latency. It replaces the bit-serial multiplier wherever N = p·q or a partial-product accumulation is needed. The valid/busy handshake is unchanged, so existing control FSMs drop in.

## Interface
- WIDTH, 256: operand width in bits; must be a multiple of DIGIT_BITS
- DIGIT_BITS, 4: multiplier bits consumed per cycle; legal values 1, 2, 4, 8
- NUM_DIGITS (localparam) = WIDTH/DIGIT_BITS: number of RUN cycles
- Clock: one clock. Reset: asynchronous, active-high.
- clk_in  input  1  clock; all state updates on the rising edge
- rst_in  input  1  asynchronous active-high reset
- a_in  input  WIDTH  multiplicand, captured on accept
- b_in  input  WIDTH  multiplier, captured on accept
- d_in  input  WIDTH  addend, captured on accept (tie to 0 for a plain multiply)
- valid_in  input  1  start request; sampled only while idle
- c_out  output  2*WIDTH  result a·b + d, held until the next result is written
- valid_out  output  1  single-cycle pulse when c_out is updated
- busy_out  output  1  high while an operation is in flight

## Operation
- States: IDLE and RUN.
- IDLE with valid_in=1 (accept):
  - a_reg←a_in; b_reg←b_in (shift register); acc←zero-extend(d_in) to 2*WIDTH; digit counter←0; go to RUN.
- IDLE with valid_in=0: no state change.
- RUN, each cycle:
  - acc←acc + ((a_reg · b_reg[DIGIT_BITS-1:0]) << (cnt·DIGIT_BITS)); b_reg shifts right by DIGIT_BITS; cnt increments.
  - Equivalent implementation: shift a_reg left by DIGIT_BITS instead of using a variable shift. Either form must give identical results.
- RUN on the cycle where cnt = NUM_DIGITS-1:
  - c_out←final acc; valid_out←1; go to IDLE.
- valid_in while busy_out=1 is ignored. It is not queued, and the inputs are not re-sampled.
- Width rule: the maximum result is (2^W−1)² + (2^W−1) = 2^(2W) − 2^W. It fits in 2W bits, so overflow cannot occur and no carry-out exists.
- Operands are unsigned. No modular reduction is performed here.
- Reset (any time, including mid-RUN):
  - State→IDLE; c_out=0; valid_out=0; busy_out=0; acc, a_reg, b_reg and cnt cleared.
  - An in-flight operation is aborted with no valid_out.

## Timing
- Accept edge E0 (valid_in=1 in IDLE).
- busy_out is high from after E0 through edge E0+NUM_DIGITS, i.e. exactly NUM_DIGITS cycles.
- c_out is updated and valid_out=1 after edge E0+NUM_DIGITS. valid_out is high for exactly one cycle.
- Latency: NUM_DIGITS cycles. Defaults: 64 cycles. DIGIT_BITS=1 gives 256 cycles; DIGIT_BITS=8 gives 32 cycles.
- Back-to-back: in the cycle where valid_out=1 the FSM is IDLE and busy_out=0. A valid_in asserted then is accepted, so sustained throughput is one result per NUM_DIGITS cycles.
- c_out is stable between valid_out pulses, including across an accept and the following RUN.
- Reset is asynchronous. Outputs go to 0 without waiting for a clock edge; release is synchronous to the next edge.

## Test plan
- Small values, W=256, DB=4: a=13, b=23, d=0 -> c_out=299; valid_out pulses exactly 64 cycles after the accept edge; busy_out high for 64 cycles.
- Accumulate: a=13, b=23, d=7 -> c_out=306. Large: a=308113484502254276214653084379069091219, b=193690634914747133184576417654126124729, d=0 -> c_out=59678696439036731833174790408137592454209857625042749229656692202628272654651.
- Corner, W=256: a=b=d=2^256−1 -> c_out=2^512−2^256. a=0, b=anything, d=5 -> 5.
- Radix sweep (W=16, DB ∈ {1,2,4,8}): a=0xFFFF, b=0x8001, d=0x0001 -> c_out=0x8000_8000 in every configuration, with latency 16/8/4/2 cycles respectively.
- Protocol: valid_in held high through RUN with changed a_in -> the first result is unaffected and no extra valid_out appears. A new request in the valid_out cycle is accepted, and the second result arrives NUM_DIGITS cycles later.
- Reset mid-RUN at cycle 10 -> busy_out, valid_out and c_out drop to 0 immediately; no valid_out follows. A fresh operation (13·23) afterwards gives 299.
